// File: rtl/bram_axis_writer_pkg.sv
// Shared D2Q9 stream definitions: lane order, lane slicing and controller state encoding.
// The read-side stream controller imports this package too, so lane order lives in one place.
package bram_axis_writer_pkg;

    localparam int LANES  = 9;
    localparam int LANE_W = 16;

    localparam int LANE_C0 = 0;
    localparam int LANE_N  = 1;
    localparam int LANE_NE = 2;
    localparam int LANE_E  = 3;
    localparam int LANE_SE = 4;
    localparam int LANE_S  = 5;
    localparam int LANE_SW = 6;
    localparam int LANE_W_ = 7;
    localparam int LANE_NW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2
    } axis_state_e;

    function automatic logic [LANE_W-1:0] lane_slice(input logic [LANES*LANE_W-1:0] data,
                                                     input int unsigned k);
        return data[k*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/bram_axis_writer_if.sv
// AXI4-Stream beat channel carrying one lattice cell (nine distribution lanes) per beat.
interface bram_axis_writer_if
    import bram_axis_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) ();
    logic                            tvalid;
    logic                            tready;
    logic [LANES*DATA_WIDTH-1:0]     tdata;
    logic [LANES*DATA_WIDTH/8-1:0]   tstrb;
    logic                            tlast;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/bram_axis_writer_strobe_decode.sv
// Per-lane write enable: a lane is written only when every byte strobe of that lane is set.
module bram_axis_writer_strobe_decode
    import bram_axis_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [LANES*DATA_WIDTH/8-1:0] strb_i,
    output logic [LANES-1:0]              lane_en_o
);
    localparam int BPL = DATA_WIDTH / 8;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_en_o[k] = &strb_i[k*BPL +: BPL];
    end
endmodule

// File: rtl/bram_axis_writer.sv
// Receives one D2Q9 frame over AXI4-Stream and writes each beat into the nine per-direction
// RAM banks at a common address; reports good completion or length mismatch as one-cycle pulses.
module bram_axis_writer
    import bram_axis_writer_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_areset,
    input  logic                          frame_arm,
    bram_axis_writer_if.slave             s00_axis,
    output logic [ADDRESS_WIDTH-1:0]      wr_addr,
    output logic [LANES*DATA_WIDTH-1:0]   wr_data,
    output logic [LANES-1:0]              wr_en,
    output logic                          frame_done,
    output logic                          frame_error,
    output logic                          busy
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    axis_state_e              state_q;
    logic [ADDRESS_WIDTH-1:0] cnt_q;
    logic [LANES-1:0]         lane_en;
    logic                     hs;

    bram_axis_writer_strobe_decode #(.DATA_WIDTH(DATA_WIDTH)) u_strb (
        .strb_i    (s00_axis.tstrb),
        .lane_en_o (lane_en)
    );

    // Ready is a pure function of state so the upstream never sees a tvalid->tready path.
    assign s00_axis.tready = (state_q != ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign hs              = s00_axis.tvalid & s00_axis.tready;

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_en       <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            wr_en       <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_arm) begin
                        state_q <= ST_RECV;
                        cnt_q   <= '0;
                    end
                end
                ST_RECV: begin
                    if (hs) begin
                        wr_addr <= cnt_q;
                        wr_data <= s00_axis.tdata;
                        wr_en   <= lane_en;
                        if (s00_axis.tlast) begin
                            state_q <= ST_IDLE;
                            if (cnt_q == LAST_ADDR) frame_done  <= 1'b1;
                            else                    frame_error <= 1'b1;
                        end else if (cnt_q == LAST_ADDR) begin
                            // Frame overran the lattice: swallow the rest until tlast.
                            state_q <= ST_FLUSH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (hs && s00_axis.tlast) begin
                        state_q     <= ST_IDLE;
                        frame_error <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_axis_writer.sv
// Scoreboard bench: a DEPTH=4 instance for framing cases and a DEPTH=2500 instance for full frames.
module tb_bram_axis_writer;
    import bram_axis_writer_pkg::*;

    localparam int DW = 16;
    localparam int TW = LANES * DW;
    localparam int SW = TW / 8;
    localparam int AW = 12;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [TW-1:0]    data;
        logic [LANES-1:0] en;
        logic             done;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rstb, arm4, armb;
    logic [AW-1:0]    wa4, wab;
    logic [TW-1:0]    wd4, wdb;
    logic [LANES-1:0] we4, web;
    logic             dn4, dnb, er4, erb, bz4, bzb;

    bram_axis_writer_if #(.DATA_WIDTH(DW)) ax4 ();
    bram_axis_writer_if #(.DATA_WIDTH(DW)) axb ();

    bram_axis_writer #(.DATA_WIDTH(DW), .DEPTH(4), .ADDRESS_WIDTH(AW)) u4 (
        .s00_axis_aclk(clk), .s00_axis_areset(rst4), .frame_arm(arm4), .s00_axis(ax4),
        .wr_addr(wa4), .wr_data(wd4), .wr_en(we4), .frame_done(dn4), .frame_error(er4), .busy(bz4));

    bram_axis_writer #(.DATA_WIDTH(DW), .DEPTH(2500), .ADDRESS_WIDTH(AW)) ub (
        .s00_axis_aclk(clk), .s00_axis_areset(rstb), .frame_arm(armb), .s00_axis(axb),
        .wr_addr(wab), .wr_data(wdb), .wr_en(web), .frame_done(dnb), .frame_error(erb), .busy(bzb));

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q4[$];
    exp_t qb[$];
    int   mst[2];
    int   mcnt[2];
    int   depth[2] = '{4, 2500};

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [TW-1:0] mk(input int i);
        logic [TW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = 16'(16'h1000 * k + i);
        return v;
    endfunction

    task automatic set_in(input int d, input logic v, input logic [TW-1:0] data,
                          input logic [SW-1:0] strb, input logic last);
        if (d == 0) begin
            ax4.tvalid = v; ax4.tdata = data; ax4.tstrb = strb; ax4.tlast = last;
        end else begin
            axb.tvalid = v; axb.tdata = data; axb.tstrb = strb; axb.tlast = last;
        end
    endtask

    // Reference behaviour of one accepted beat, evaluated just before the handshake edge.
    task automatic model(input int d, input logic [TW-1:0] data, input logic [SW-1:0] strb,
                         input logic last);
        exp_t e;
        e.addr = AW'(mcnt[d]); e.data = data; e.done = 1'b0; e.err = 1'b0;
        for (int k = 0; k < LANES; k++) e.en[k] = (strb[2*k +: 2] == 2'b11);
        if (mst[d] == 1) begin
            if (last) begin
                mst[d] = 0;
                if (mcnt[d] == depth[d] - 1) e.done = 1'b1; else e.err = 1'b1;
            end else if (mcnt[d] == depth[d] - 1) mst[d] = 2;
            else mcnt[d]++;
            if (d == 0) q4.push_back(e); else qb.push_back(e);
        end else if (mst[d] == 2 && last) begin
            mst[d] = 0; e.en = '0; e.err = 1'b1;
            if (d == 0) q4.push_back(e); else qb.push_back(e);
        end
    endtask

    task automatic beat(input int d, input logic [TW-1:0] data, input logic [SW-1:0] strb,
                        input logic last);
        bit ok = 0;
        int n = 0;
        set_in(d, 1'b1, data, strb, last);
        while (!ok && n < 50) begin
            @(negedge clk);
            if ((d == 0) ? ax4.tready : axb.tready) begin
                ok = 1;
                model(d, data, strb, last);
            end
            @(posedge clk); #1;
            n++;
        end
        set_in(d, 1'b0, '0, '0, 1'b0);
        chk("handshake_timeout", 192'(ok), 192'd1);
    endtask

    task automatic arm(input int d);
        if (d == 0) arm4 = 1'b1; else armb = 1'b1;
        @(posedge clk); #1;
        if (d == 0) arm4 = 1'b0; else armb = 1'b0;
        if (mst[d] == 0) begin mst[d] = 1; mcnt[d] = 0; end
    endtask

    task automatic idle_chk(input int d);
        @(negedge clk);
        if (d == 0) chk("idle_tready_busy", {ax4.tready, bz4}, 0);
        else        chk("idle_tready_busy", {axb.tready, bzb}, 0);
        @(posedge clk); #1;
    endtask

    task automatic mon(input int d);
        exp_t e;
        logic [AW-1:0] a; logic [TW-1:0] w; logic [LANES-1:0] en; logic dn, er;
        if (d == 0) begin a = wa4; w = wd4; en = we4; dn = dn4; er = er4; end
        else        begin a = wab; w = wdb; en = web; dn = dnb; er = erb; end
        if (en != '0 || dn || er) begin
            if ((d == 0 && q4.size() == 0) || (d == 1 && qb.size() == 0)) begin
                chk("spurious_write_or_pulse", {en, dn, er}, 0);
            end else begin
                e = (d == 0) ? q4.pop_front() : qb.pop_front();
                chk("wr_en", en, e.en);
                chk("frame_done", dn, e.done);
                chk("frame_error", er, e.err);
                if (e.en != '0) begin
                    chk("wr_addr", a, e.addr);
                    chk("wr_data", w, e.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst4 = 1'b1; rstb = 1'b1; arm4 = 1'b0; armb = 1'b0;
        set_in(0, 1'b0, '0, '0, 1'b0);
        set_in(1, 1'b0, '0, '0, 1'b0);
        mst = '{0, 0}; mcnt = '{0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_d4", {wa4, wd4, we4, dn4, er4, bz4, ax4.tready}, 0);
        chk("reset_d2500", {wab, wdb, web, dnb, erb, bzb, axb.tready}, 0);
        @(posedge clk); #1;
        rst4 = 1'b0; rstb = 1'b0;

        // Good frame, back-to-back beats.
        arm(0);
        for (int i = 0; i < 4; i++) beat(0, mk(i), '1, i == 3);
        idle_chk(0);

        // Beat offered before arm must stall, then tvalid toggles every other cycle.
        set_in(0, 1'b1, mk(16), '1, 1'b0);
        repeat (3) begin
            @(negedge clk); chk("pre_arm_stall", ax4.tready, 0);
            @(posedge clk); #1;
        end
        arm(0);
        for (int i = 0; i < 4; i++) begin
            beat(0, mk(16 + i), '1, i == 3);
            @(posedge clk); #1;
        end
        idle_chk(0);

        // Short frame: tlast on beat 1.
        arm(0);
        for (int i = 0; i < 2; i++) beat(0, mk(32 + i), '1, i == 1);
        idle_chk(0);

        // Long frame: six beats, last two flushed.
        arm(0);
        for (int i = 0; i < 6; i++) beat(0, mk(48 + i), '1, i == 5);
        idle_chk(0);

        // Partial strobe on lane 1 of beat 0; arm pulse mid-frame must be ignored.
        arm(0);
        beat(0, mk(64), 18'h3FFF3, 1'b0);
        arm(0);
        for (int i = 1; i < 4; i++) beat(0, mk(64 + i), '1, i == 3);
        idle_chk(0);

        // Reset in the middle of a full-size frame, then a complete 2500-beat frame.
        arm(1);
        for (int i = 0; i < 3; i++) beat(1, mk(i), '1, 1'b0);
        rstb = 1'b1;
        @(posedge clk); #1;
        mst[1] = 0; mcnt[1] = 0;
        @(negedge clk);
        chk("midframe_reset", {wab, wdb, web, dnb, erb, bzb, axb.tready}, 0);
        @(posedge clk); #1;
        rstb = 1'b0;
        arm(1);
        for (int i = 0; i < 2500; i++) beat(1, mk(i), '1, i == 2499);
        idle_chk(1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained_d4", 192'(q4.size()), 0);
        chk("scoreboard_drained_d2500", 192'(qb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
